// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one outstanding fetch at a time and queues
// {instr, pc+4} pairs for the decode stage; redirects flush the queue and refetch.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc4,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_pc4   [DEPTH];

  logic            w_pop;
  logic            w_push;
  logic [CW-1:0]   w_count_after;
  logic            w_space;

  // Handshake: a request stays asserted with a stable address until the cycle
  // imem_ack is high; that cycle both sides consider the transfer complete.
  assign w_pop  = (r_count != '0) && !stall && !redirect;
  assign w_push = (r_state == S_REQ) && imem_ack && !redirect;

  always_comb begin
    w_count_after = r_count;
    if (w_push) w_count_after = w_count_after + CW'(1);
    if (w_pop)  w_count_after = w_count_after - CW'(1);
  end

  assign w_space = (w_count_after < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc4[i]   <= '0;
      end
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_req      <= 1'b0;
      // An unacked request must have its late ack absorbed in DROP.
      case (r_state)
        S_REQ:   r_state <= imem_ack ? S_IDLE : S_DROP;
        S_DROP:  r_state <= imem_ack ? S_IDLE : S_DROP;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_count <= w_count_after;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push) begin
        r_instr[r_wr_ptr] <= imem_rdata;
        r_pc4[r_wr_ptr]   <= r_fetch_pc + 32'd4;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_fetch_pc        <= r_fetch_pc + 32'd4;
      end
      case (r_state)
        S_IDLE: begin
          if (w_space) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack && !w_space) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_DROP: begin
          if (imem_ack) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_fetch_pc[AW-1:0];
  assign out_valid = (r_count != '0);
  assign out_instr = r_instr[r_rd_ptr];
  assign out_pc4   = r_pc4[r_rd_ptr];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a memory responder with random latency and an
// in-order queue of expected fetch addresses drive all output checks.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          AW       = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          stall = 1'b0;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc4;
  logic [1:0]    dbg_state;

  fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];      // pcs of entries expected in the queue, head first
  logic [31:0] exp_fetch;     // pc of the next instruction that should be fetched
  bit          mem_busy;
  int          mem_cnt;
  logic [AW-1:0] mem_addr;
  int          lat_lo, lat_hi;
  bit          drv_stall, drv_redirect, redir_on_ack;
  logic [31:0] drv_rpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [AW-1:0] a);
    return ({{(32-AW){1'b0}}, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- one clock of driving + checking ----------------
  task automatic cycle();
    logic        ack, pop, accept;
    logic [31:0] head;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_pc4", out_pc4, head + 32'd4);
      check("out_instr", out_instr, instr_of(head[AW-1:0]));
    end
    if (imem_req) begin
      if (mem_busy) begin
        check("addr_hold", 32'(imem_addr), 32'(mem_addr));
      end else begin
        check("req_addr", 32'(imem_addr), 32'(exp_fetch[AW-1:0]));
        check("req_space", 32'(exp_q.size() < DEPTH), 32'd1);
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(lat_hi, lat_lo));
        mem_addr = imem_addr;
      end
    end
    ack = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_ack    = ack;
    imem_rdata  = ack ? instr_of(mem_addr) : $urandom();
    stall       = drv_stall;
    redirect    = drv_redirect || (redir_on_ack && ack && imem_req);
    redirect_pc = drv_rpc;
    pop    = (exp_q.size() != 0) && !stall && !redirect;
    accept = ack && imem_req && !redirect;
    if (redirect) begin
      exp_q.delete();
      exp_fetch = redirect_pc;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  endtask

  task automatic reset_pulse(input bit mid);
    @(posedge clk);
    #2;
    if (mid) check("pre_reset_req", 32'(imem_req), 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    redirect   = 1'b0;
    stall      = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(RESET_PC[AW-1:0]));
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc4", out_pc4, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;  // stray ack stays high into the first post-reset edge
    exp_q.delete();
    exp_fetch    = RESET_PC;
    mem_busy     = 1'b0;
    drv_stall    = 1'b0;
    drv_redirect = 1'b0;
    redir_on_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    case ($urandom_range(3, 0))
      0:       p = 32'hFFFF_FFF8;
      1:       p = 32'h0000_00F8;
      default: p = $urandom();
    endcase
    p[1:0] = 2'b00;
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    lat_lo = 0; lat_hi = 0;
    drv_stall = 0; drv_redirect = 0; redir_on_ack = 0; drv_rpc = '0;
    reset_pulse(1'b0);

    // steady stream, immediate ack
    repeat (12) cycle();

    // stall held: queue fills, then requests stop
    drv_stall = 1'b1;
    repeat (12) cycle();
    check("full_no_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    drv_stall = 1'b0;
    repeat (12) cycle();

    // redirect with 3 queued and a request pending
    drv_redirect = 1'b1; drv_rpc = 32'h0; cycle(); drv_redirect = 1'b0;
    drv_stall = 1'b1;
    n = 0;
    while (exp_q.size() < 3 && n < 30) begin cycle(); n++; end
    if (n == 30) check("fill_timeout", 32'(n), 32'd0);
    lat_lo = 3; lat_hi = 3;
    cycle();
    drv_redirect = 1'b1; drv_rpc = 32'h40;
    cycle();
    drv_redirect = 1'b0; drv_stall = 1'b0;
    cycle();
    check("drop_state", 32'(dbg_state), 32'd2);
    check("drop_no_req", 32'(imem_req), 32'd0);
    lat_lo = 0; lat_hi = 0;
    repeat (15) cycle();

    // redirect landing on the ack cycle
    redir_on_ack = 1'b1; drv_rpc = 32'h0000_01A4;
    repeat (3) cycle();
    redir_on_ack = 1'b0;
    repeat (8) cycle();

    // address wrap at the top of the AW space
    drv_redirect = 1'b1; drv_rpc = 32'h0000_00FC; cycle(); drv_redirect = 1'b0;
    repeat (8) cycle();

    // randomized traffic
    lat_lo = 0; lat_hi = 2;
    for (int i = 0; i < 600; i++) begin
      drv_stall    = ($urandom_range(99, 0) < 30);
      drv_redirect = ($urandom_range(99, 0) < 4);
      drv_rpc      = rand_pc();
      cycle();
    end
    drv_stall = 1'b0; drv_redirect = 1'b0;

    // reset in the middle of a pending request, stray ack afterwards
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (!(mem_busy && imem_req) && n < 20) begin cycle(); n++; end
    if (n == 20) check("busy_timeout", 32'(n), 32'd0);
    reset_pulse(1'b1);
    lat_lo = 0; lat_hi = 1;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
